// File: rtl/ex_stage_if.sv
// Decode-to-execute bundle: operands and instruction in, ALU result, branch and MEM-stage registers out.
// Latency: none, wires only.
// Backpressure: the state field is the run/hold qualifier for every register behind this bundle.
interface ex_stage_if;
    logic        state;
    logic [15:0] ex_ir;
    logic [15:0] reg_A;
    logic [15:0] reg_B;
    logic [15:0] smdr;
    logic [15:0] ALUo;
    logic        jump;
    logic [15:0] mem_ir;
    logic [15:0] reg_C;
    logic [15:0] smdr1;
    logic        dw;
    logic        zf;
    logic        nf;
    logic        cf;

    // Decode side: drives instruction and operands, observes results.
    modport master (
        output state, ex_ir, reg_A, reg_B, smdr,
        input  ALUo, jump, mem_ir, reg_C, smdr1, dw, zf, nf, cf
    );

    // Execute side.
    modport slave (
        input  state, ex_ir, reg_A, reg_B, smdr,
        output ALUo, jump, mem_ir, reg_C, smdr1, dw, zf, nf, cf
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: 16-bit ALU, condition flags, branch/JMPR resolution and EX/MEM pipeline registers.
// Latency: ALUo and jump combinational, reg_C/mem_ir/smdr1/dw/flags one edge later.
// Backpressure: when state is not exec every register holds; combinational outputs keep tracking inputs.
module ex_stage (
    input  logic      clock,
    input  logic      reset,
    ex_stage_if.slave ex
);
    localparam logic EXEC = 1'b1;

    localparam logic [4:0] NOP  = 5'b00000, HALT = 5'b00001, LOAD = 5'b00010, STORE = 5'b00011;
    localparam logic [4:0] SLL  = 5'b00100, SLA  = 5'b00101, SRL  = 5'b00110, SRA   = 5'b00111;
    localparam logic [4:0] ADD  = 5'b01000, ADDI = 5'b01001, SUB  = 5'b01010, SUBI  = 5'b01011;
    localparam logic [4:0] CMP  = 5'b01100, AND  = 5'b01101, OR   = 5'b01110, XOR   = 5'b01111;
    localparam logic [4:0] LDIH = 5'b10000, ADDC = 5'b10001, SUBC = 5'b10010;
    localparam logic [4:0] JUMP = 5'b11000, JMPR = 5'b11001, BZ   = 5'b11010, BNZ   = 5'b11011;
    localparam logic [4:0] BN   = 5'b11100, BNN  = 5'b11101, BC   = 5'b11110, BNC   = 5'b11111;

    logic [4:0]         op;
    logic [3:0]         sh;
    logic [16:0]        sum;
    logic [15:0]        alu;
    logic [15:0]        sll_res;
    logic signed [15:0] sra_res;
    logic               upd_zn;
    logic               upd_c;

    assign op      = ex.ex_ir[15:11];
    assign sh      = ex.reg_B[3:0];
    assign sll_res = ex.reg_A << sh;
    assign sra_res = $signed(ex.reg_A) >>> sh;
    assign ex.ALUo = alu;

    // ALU: 17-bit sum so bit 16 carries the carry (add) or borrow (subtract).
    always_comb begin
        sum = 17'd0;
        alu = 16'd0;
        case (op)
            ADD, ADDI, LDIH, LOAD, STORE, JMPR, BZ, BNZ, BN, BNN, BC, BNC: begin
                sum = {1'b0, ex.reg_A} + {1'b0, ex.reg_B};
                alu = sum[15:0];
            end
            ADDC: begin
                sum = {1'b0, ex.reg_A} + {1'b0, ex.reg_B} + {16'd0, ex.cf};
                alu = sum[15:0];
            end
            SUB, SUBI, CMP: begin
                sum = {1'b0, ex.reg_A} - {1'b0, ex.reg_B};
                alu = sum[15:0];
            end
            SUBC: begin
                sum = {1'b0, ex.reg_A} - {1'b0, ex.reg_B} - {16'd0, ex.cf};
                alu = sum[15:0];
            end
            AND:     alu = ex.reg_A & ex.reg_B;
            OR:      alu = ex.reg_A | ex.reg_B;
            XOR:     alu = ex.reg_A ^ ex.reg_B;
            SLL:     alu = sll_res;
            SLA:     alu = {ex.reg_A[15], sll_res[14:0]};
            SRL:     alu = ex.reg_A >> sh;
            SRA:     alu = sra_res;
            default: alu = 16'd0;
        endcase
    end

    // Which opcodes write zero/negative and which additionally write carry.
    always_comb begin
        upd_zn = 1'b0;
        upd_c  = 1'b0;
        case (op)
            ADD, ADDI, ADDC, SUB, SUBI, SUBC, CMP: begin
                upd_zn = 1'b1;
                upd_c  = 1'b1;
            end
            AND, OR, XOR, SLL, SRL, SLA, SRA, LDIH: upd_zn = 1'b1;
            default: ;
        endcase
    end

    // Branch resolution from the flags as they stand before this edge; JUMP is handled upstream.
    always_comb begin
        case (op)
            JMPR:    ex.jump = 1'b1;
            BZ:      ex.jump = ex.zf;
            BNZ:     ex.jump = ~ex.zf;
            BN:      ex.jump = ex.nf;
            BNN:     ex.jump = ~ex.nf;
            BC:      ex.jump = ex.cf;
            BNC:     ex.jump = ~ex.cf;
            default: ex.jump = 1'b0;
        endcase
    end

    // EX/MEM pipeline registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex.mem_ir <= 16'd0;
            ex.reg_C  <= 16'd0;
            ex.smdr1  <= 16'd0;
            ex.dw     <= 1'b0;
        end else if (ex.state == EXEC) begin
            ex.mem_ir <= ex.ex_ir;
            ex.reg_C  <= alu;
            ex.smdr1  <= ex.smdr;
            ex.dw     <= (op == STORE);
        end
    end

    // Condition flags, written only by ALU-class opcodes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex.zf <= 1'b0;
            ex.nf <= 1'b0;
            ex.cf <= 1'b0;
        end else if (ex.state == EXEC) begin
            if (upd_zn) begin
                ex.zf <= (alu == 16'd0);
                ex.nf <= alu[15];
            end
            if (upd_c) begin
                ex.cf <= sum[16];
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    ex_stage_if bus ();

    ex_stage dut (
        .clock (clock),
        .reset (reset),
        .ex    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] alu;
        logic        jmp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] alu, input logic jmp, input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.alu = alu; v.jmp = jmp; v.name = name;
        return v;
    endfunction

    function automatic logic [15:0] word(input logic [4:0] op);
        return {op, 3'd2, 8'h00};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] sd);
        bus.state = st;
        bus.ex_ir = word(op);
        bus.reg_A = a;
        bus.reg_B = b;
        bus.smdr  = sd;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        drive(1'b0, 5'b00000, 16'h0000, 16'h0000, 16'h0000);

        // Combinational vectors, all taken with flags at reset value (zf=nf=cf=0).
        tbl.push_back(mk(5'b01000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, "add_wrap"));
        tbl.push_back(mk(5'b01001, 16'h1234, 16'h1111, 16'h2345, 1'b0, "addi"));
        tbl.push_back(mk(5'b01010, 16'h0002, 16'h0005, 16'hFFFD, 1'b0, "sub_neg"));
        tbl.push_back(mk(5'b00111, 16'h8001, 16'h0001, 16'hC000, 1'b0, "sra"));
        tbl.push_back(mk(5'b00110, 16'h8001, 16'h0001, 16'h4000, 1'b0, "srl"));
        tbl.push_back(mk(5'b00100, 16'h8001, 16'h0001, 16'h0002, 1'b0, "sll"));
        tbl.push_back(mk(5'b00101, 16'h8001, 16'h0001, 16'h8002, 1'b0, "sla"));
        tbl.push_back(mk(5'b00100, 16'h0001, 16'h0013, 16'h0008, 1'b0, "sll_low4"));
        tbl.push_back(mk(5'b00111, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, "sra_15"));
        tbl.push_back(mk(5'b01101, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, "and"));
        tbl.push_back(mk(5'b01110, 16'hF000, 16'h000F, 16'hF00F, 1'b0, "or"));
        tbl.push_back(mk(5'b01111, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0, "xor"));
        tbl.push_back(mk(5'b10000, 16'h0000, 16'h5500, 16'h5500, 1'b0, "ldih"));
        tbl.push_back(mk(5'b10001, 16'h0001, 16'h0001, 16'h0002, 1'b0, "addc_cf0"));
        tbl.push_back(mk(5'b10010, 16'h0005, 16'h0003, 16'h0002, 1'b0, "subc_cf0"));
        tbl.push_back(mk(5'b00000, 16'h1234, 16'h0001, 16'h0000, 1'b0, "nop"));
        tbl.push_back(mk(5'b00001, 16'h1234, 16'h0001, 16'h0000, 1'b0, "halt"));
        tbl.push_back(mk(5'b11000, 16'h1234, 16'h0001, 16'h0000, 1'b0, "jump_op"));
        tbl.push_back(mk(5'b10011, 16'h1234, 16'h0001, 16'h0000, 1'b0, "undef"));
        tbl.push_back(mk(5'b11001, 16'h0100, 16'h0020, 16'h0120, 1'b1, "jmpr"));
        tbl.push_back(mk(5'b11010, 16'h0010, 16'h0001, 16'h0011, 1'b0, "bz"));
        tbl.push_back(mk(5'b11011, 16'h0010, 16'h0002, 16'h0012, 1'b1, "bnz"));
        tbl.push_back(mk(5'b11100, 16'h0010, 16'h0003, 16'h0013, 1'b0, "bn"));
        tbl.push_back(mk(5'b11101, 16'h0010, 16'h0004, 16'h0014, 1'b1, "bnn"));
        tbl.push_back(mk(5'b11110, 16'h0010, 16'h0005, 16'h0015, 1'b0, "bc"));
        tbl.push_back(mk(5'b11111, 16'h0010, 16'h0006, 16'h0016, 1'b1, "bnc"));

        #2;
        chk("rst_mem_ir", bus.mem_ir, 16'h0000);
        chk("rst_reg_C",  bus.reg_C,  16'h0000);
        chk("rst_smdr1",  bus.smdr1,  16'h0000);
        chk("rst_dw",     {15'd0, bus.dw}, 16'd0);
        chk("rst_flags",  {13'd0, bus.zf, bus.nf, bus.cf}, 16'd0);

        @(negedge clock);
        reset = 1'b1;

        // Table: state held low so flags stay at zero throughout.
        foreach (tbl[i]) begin
            drive(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, 16'h0000);
            #1;
            chk({tbl[i].name, "_alu"},  bus.ALUo, tbl[i].alu);
            chk({tbl[i].name, "_jump"}, {15'd0, bus.jump}, {15'd0, tbl[i].jmp});
        end
        chk("hold_reg_C_after_table", bus.reg_C, 16'h0000);

        // ADD wrap sets zf and cf, then ADDC consumes the carry.
        tick();
        drive(1'b1, 5'b01000, 16'hFFFF, 16'h0001, 16'h0000);
        #1;
        chk("add_alu", bus.ALUo, 16'h0000);
        tick();
        chk("add_reg_C",  bus.reg_C, 16'h0000);
        chk("add_mem_ir", bus.mem_ir, word(5'b01000));
        chk("add_flags",  {13'd0, bus.zf, bus.nf, bus.cf}, 16'b101);
        drive(1'b1, 5'b10001, 16'h0001, 16'h0001, 16'h0000);
        #1;
        chk("addc_alu", bus.ALUo, 16'h0003);
        tick();
        chk("addc_reg_C", bus.reg_C, 16'h0003);
        chk("addc_flags", {13'd0, bus.zf, bus.nf, bus.cf}, 16'b000);

        // SUB borrow, then branches on the resulting flags.
        drive(1'b1, 5'b01010, 16'h0002, 16'h0005, 16'h0000);
        #1;
        chk("sub_alu", bus.ALUo, 16'hFFFD);
        tick();
        chk("sub_flags", {13'd0, bus.zf, bus.nf, bus.cf}, 16'b011);
        drive(1'b1, 5'b11110, 16'h0010, 16'h0004, 16'h0000);
        #1;
        chk("bc_jump", {15'd0, bus.jump}, 16'd1);
        chk("bc_alu",  bus.ALUo, 16'h0014);
        bus.ex_ir = word(5'b11111);
        #1;
        chk("bnc_jump", {15'd0, bus.jump}, 16'd0);
        bus.ex_ir = word(5'b11100);
        #1;
        chk("bn_jump", {15'd0, bus.jump}, 16'd1);
        bus.ex_ir = word(5'b11110);
        tick();
        chk("bc_keeps_flags", {13'd0, bus.zf, bus.nf, bus.cf}, 16'b011);
        chk("bc_reg_C", bus.reg_C, 16'h0014);
        #1;
        chk("bc_b2b_jump", {15'd0, bus.jump}, 16'd1);

        // STORE then NOP.
        drive(1'b1, 5'b00011, 16'h0020, 16'h0003, 16'hBEEF);
        tick();
        chk("st_reg_C", bus.reg_C, 16'h0023);
        chk("st_smdr1", bus.smdr1, 16'hBEEF);
        chk("st_dw",    {15'd0, bus.dw}, 16'd1);
        chk("st_flags", {13'd0, bus.zf, bus.nf, bus.cf}, 16'b011);
        drive(1'b1, 5'b00000, 16'h1111, 16'h2222, 16'h0000);
        tick();
        chk("nop_dw",     {15'd0, bus.dw}, 16'd0);
        chk("nop_flags",  {13'd0, bus.zf, bus.nf, bus.cf}, 16'b011);
        chk("nop_reg_C",  bus.reg_C, 16'h0000);
        chk("nop_mem_ir", bus.mem_ir, word(5'b00000));

        // Three held cycles with changing instructions.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, (k == 1) ? 5'b00011 : 5'b01000, 16'h0100 + 16'(k), 16'h0001, 16'hAAAA);
            tick();
            chk("hold_mem_ir", bus.mem_ir, word(5'b00000));
            chk("hold_reg_C",  bus.reg_C, 16'h0000);
            chk("hold_smdr1",  bus.smdr1, 16'h0000);
            chk("hold_dw_flags", {12'd0, bus.dw, bus.zf, bus.nf, bus.cf}, 16'b0011);
        end
        drive(1'b1, 5'b01100, 16'h0007, 16'h0007, 16'h0000);
        tick();
        chk("cmp_flags",  {13'd0, bus.zf, bus.nf, bus.cf}, 16'b100);
        chk("cmp_mem_ir", bus.mem_ir, word(5'b01100));

        // Asynchronous reset mid-cycle with zf set.
        #3;
        reset = 1'b0;
        #1;
        chk("arst_mem_ir", bus.mem_ir, 16'h0000);
        chk("arst_reg_C",  bus.reg_C, 16'h0000);
        chk("arst_dw_flags", {12'd0, bus.dw, bus.zf, bus.nf, bus.cf}, 16'd0);
        #1;
        reset = 1'b1;
        drive(1'b1, 5'b01000, 16'h0001, 16'h0001, 16'h0000);
        tick();
        chk("post_rst_reg_C", bus.reg_C, 16'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit five-stage pipeline. It sits directly downstream of the decode stage and consumes its `ex_ir`, `reg_A`, `reg_B` and `smdr`. It computes the ALU result, holds the condition flags and resolves conditional branches and `JMPR`. Results are registered into the MEM-stage pipeline registers. The combinational `ALUo` and `jump` outputs feed decode-stage forwarding, decode-stage flushing and the fetch stage.

## Interface
- No parameters; data width fixed at 16, opcode field `[15:11]`, destination field `[10:8]`.
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clock` in 1: rising-edge clock.
  - `reset` in 1: asynchronous, active-low.
- `state` in 1: pipeline run state; registers advance only when `state == `exec`.
- `ex_ir` in 16: instruction in EX.
- `reg_A`, `reg_B` in 16: operands, already forwarded by decode.
- `smdr` in 16: store data.
- `ALUo` out 16: combinational ALU result.
- `jump` out 1: combinational; branch or `JMPR` taken. Target = `ALUo`.
- `mem_ir` out 16, registered: instruction passed to MEM.
- `reg_C` out 16, registered: ALU result / memory address.
- `smdr1` out 16, registered: store data to MEM.
- `dw` out 1, registered: data-memory write enable.
- `zf`, `nf`, `cf` out 1 each, registered: zero, negative and carry flags.

## Operation
Opcodes per `define.v`:
- NOP 00000, HALT 00001, LOAD 00010, STORE 00011
- SLL 00100, SLA 00101, SRL 00110, SRA 00111
- ADD 01000, ADDI 01001, SUB 01010, SUBI 01011, CMP 01100
- AND 01101, OR 01110, XOR 01111
- LDIH 10000, ADDC 10001, SUBC 10010
- JUMP 11000, JMPR 11001, BZ 11010, BNZ 11011, BN 11100, BNN 11101, BC 11110, BNC 11111

`ALUo` is computed with a 17-bit internal sum; bit 16 is `cout`.
- ADD, ADDI, LDIH, LOAD, STORE, JMPR, all Bxx: `A+B`. This gives the address or target for the memory and branch ops.
- ADDC: `A+B+cf`.
- SUB, SUBI, CMP: `A-B`. SUBC: `A-B-cf`. For all subtracts, `cout` = borrow, i.e. 1 when the unsigned subtrahend exceeds `A`.
- AND, OR, XOR: bitwise.
- Shift amount is `B[3:0]`:
  - SLL: `A<<n`.
  - SRL: logical right.
  - SRA: arithmetic right (sign-fill).
  - SLA: `{A[15], (A<<n)[14:0]}`.
- NOP, HALT, JUMP, any undefined code: `ALUo = 0`.

Flag update rules, at a clock edge with `state == exec`:
- `zf <= (ALUo == 0)` and `nf <= ALUo[15]` for: ADD, ADDI, ADDC, SUB, SUBI, SUBC, CMP, AND, OR, XOR, SLL, SRL, SLA, SRA, LDIH.
- `cf <= cout` for ADD, ADDI, ADDC, SUB, SUBI, SUBC, CMP only.
- All other opcodes leave all flags unchanged.

`jump` is combinational from the `ex_ir` opcode and the current registered flags:
- JMPR: always 1.
- BZ: `zf`. BNZ: `!zf`.
- BN: `nf`. BNN: `!nf`.
- BC: `cf`. BNC: `!cf`.
- Anything else, including JUMP (resolved in fetch/decode): 0.

Pipeline registers, at a clock edge with `state == exec`:
- `mem_ir <= ex_ir`
- `reg_C <= ALUo`
- `smdr1 <= smdr`
- `dw <= (opcode == STORE)`

## Timing
- Reset (async, `reset == 0`): `mem_ir`, `reg_C`, `smdr1` = 0; `dw`, `zf`, `nf`, `cf` = 0. Takes effect immediately, mid-instruction included. The first edge after release behaves normally.
- `state != exec`: all registers hold. `ALUo` and `jump` still track their inputs combinationally.
- Latency:
  - ALU result is visible on `ALUo` in the same cycle.
  - `reg_C` / `mem_ir` are valid one edge later.
  - Flags written by instruction i are visible to the branch in EX at i+1, since they are registered at the same edge that moves i+1 into EX.
- A branch reads the pre-edge flags. Flags never change on branch opcodes, so back-to-back branches see identical flags.
- ADDC/SUBC use the pre-edge `cf`. Their new `cf` is registered at the same edge.
- Wrap-around: sums are truncated to 16 bits; the overflow bit goes only to `cf`.

## Test plan
- ADD, A=16'hFFFF, B=16'h0001 -> `ALUo` 0. After the edge: `reg_C` 0, `zf` 1, `cf` 1, `nf` 0. Next cycle ADDC with A=1, B=1 -> `ALUo` 3.
- SUB, A=2, B=5 -> `ALUo` 16'hFFFD. After the edge: `nf` 1, `cf` 1 (borrow). Next cycle BC with A=16'h0010, B=16'h0004 -> `jump` 1, `ALUo` 16'h0014. BNC instead -> `jump` 0.
- Shifts with A=16'h8001, n=1:
  - SRA -> 16'hC000
  - SRL -> 16'h4000
  - SLL -> 16'h0002
  - SLA -> 16'h8002
- STORE, A=16'h0020, B=3, smdr=16'hBEEF -> after the edge: `reg_C` 16'h0023, `smdr1` 16'hBEEF, `dw` 1. A following NOP clears `dw` to 0 and leaves the flags unchanged.
- Hold `state` low for 3 cycles while varying `ex_ir` -> all registered outputs are frozen. Then CMP A=7, B=7 with `state` high -> `zf` 1, `mem_ir` = CMP word.
- Assert `reset` low mid-cycle after the flags are set -> all registered outputs go to 0 before the next edge.
